// File: rtl/pulse_gen_pkg.sv
// Shared types and default build constants for the one-shot pulse generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } pulse_gen_st_e;

    localparam int CNT_W_DEFAULT      = 8;
    localparam int GAP_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/pulse_gen_cnt.sv
// Loadable down-counter with a zero flag; load wins over decrement and it
// saturates at zero instead of wrapping.
module pulse_gen_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_gen.sv
// One-shot pulse generator: a trigger strobe starts a pulse of len_i cycles,
// followed by a fixed refractory gap. All outputs come straight from flops.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             retrig_en_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             drop_o
);

    // A zero-length gap skips GAP entirely, so its load value is never used.
    localparam logic [CNT_W-1:0] GAP_LOAD =
        (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

    pulse_gen_st_e state_q, state_d;
    logic          pulse_q, pulse_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          drop_q, drop_d;

    logic             lenValid;
    logic [CNT_W-1:0] lenLoad;
    logic             cntLoad, cntDec, cntZero;
    logic             gapLoad, gapDec, gapZero;

    assign lenValid = (len_i != '0);
    assign lenLoad  = len_i - CNT_W'(1);

    pulse_gen_cnt #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cntLoad),
        .load_val_i (lenLoad),
        .dec_i      (cntDec),
        .zero_o     (cntZero)
    );

    pulse_gen_cnt #(.W(CNT_W)) u_gcnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (gapLoad),
        .load_val_i (GAP_LOAD),
        .dec_i      (gapDec),
        .zero_o     (gapZero)
    );

    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        cntLoad = 1'b0;
        cntDec  = 1'b0;
        gapLoad = 1'b0;
        gapDec  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trig_i) begin
                    if (lenValid) begin
                        state_d = ACTIVE;
                        cntLoad = 1'b1;
                        pulse_d = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end

            // An accepted retrigger outranks end-of-pulse, keeping the level high.
            ACTIVE: begin
                pulse_d = 1'b1;
                if (trig_i && retrig_en_i && lenValid) begin
                    cntLoad = 1'b1;
                end else begin
                    drop_d = trig_i;
                    if (cntZero) begin
                        pulse_d = 1'b0;
                        done_d  = 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = GAP;
                            gapLoad = 1'b1;
                        end
                    end else begin
                        cntDec = 1'b1;
                    end
                end
            end

            GAP: begin
                drop_d = trig_i;
                if (gapZero) begin
                    state_d = IDLE;
                end else begin
                    gapDec = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign pulse_o = pulse_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign drop_o  = drop_q;

endmodule
